// File: rtl/clk_div_reconfig_pkg.sv
// Shared types and constants for the divider reconfiguration sequencer.
package clk_div_reconfig_pkg;

    typedef enum logic [2:0] {
        ST_STOP     = 3'd0,
        ST_HOLD_RST = 3'd1,
        ST_APPLY    = 3'd2,
        ST_ENABLE   = 3'd3,
        ST_RUN      = 3'd4
    } state_e;

    localparam int unsigned MIN_RATIO = 2;

endpackage

// File: rtl/clk_div_wait_cnt.sv
// Loadable down-counter that saturates at zero; times the drain and reset-hold phases.
module clk_div_wait_cnt #(
    parameter int DIV_W = 32
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [DIV_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/clk_div_reconfig_ctrl.sv
// Sequences glitch-free divide-ratio changes (stop, drain, reset, load, re-enable)
// and the divider power-up, driving the divider's enable, ratio and reset.
module clk_div_reconfig_ctrl
    import clk_div_reconfig_pkg::*;
#(
    parameter int DIV_W         = 32,
    parameter int DEFAULT_RATIO = 2,
    parameter int MAX_RATIO     = 1024,
    parameter int RST_CYCLES    = 2
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_req_valid,
    input  logic [DIV_W-1:0] i_req_ratio,
    output logic             o_req_ready,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_div_ratio,
    output logic             o_div_clk_en,
    output logic             o_div_rst_n,
    output logic [2:0]       o_dbg_state
);

    localparam logic [DIV_W-1:0] DEF_R   = DIV_W'(DEFAULT_RATIO);
    localparam logic [DIV_W-1:0] MIN_R   = DIV_W'(MIN_RATIO);
    localparam logic [DIV_W-1:0] MAX_R   = DIV_W'(MAX_RATIO);
    localparam logic [DIV_W-1:0] RST_LEN = DIV_W'(RST_CYCLES);

    state_e           state_q, state_d;
    logic             armed_q, armed_d;
    logic             pend_q;
    logic [DIV_W-1:0] pend_ratio_q;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [DIV_W-1:0] cnt_val;
    logic [DIV_W-1:0] wait_len;
    logic             wait_done;
    logic             accept, legal, same;

    // Handshake: a request transfers on a clock edge where i_req_valid and
    // o_req_ready are both high; o_req_ready is high only in RUN, and a stalled
    // requester keeps valid and ratio stable until the transfer.
    assign accept      = i_req_valid && o_req_ready;
    assign legal       = (i_req_ratio >= MIN_R) && (i_req_ratio <= MAX_R);
    assign same        = (i_req_ratio == o_div_ratio);
    assign o_dbg_state = state_q;

    // A wait of N cycles: the first cycle loads N-2, then count down to zero.
    assign wait_len  = (state_q == ST_STOP) ? o_div_ratio : RST_LEN;
    assign wait_done = armed_q ? cnt_zero : (wait_len <= DIV_W'(1));

    clk_div_wait_cnt #(.DIV_W(DIV_W)) u_wait_cnt (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (cnt_load),
        .i_dec      (cnt_dec),
        .i_load_val (cnt_val),
        .o_zero     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            ST_RUN: begin
                if (accept && legal && !same) state_d = ST_STOP;
            end
            ST_STOP, ST_HOLD_RST: begin
                if (wait_done) begin
                    armed_d = 1'b0;
                    state_d = (state_q == ST_STOP) ? ST_HOLD_RST : ST_APPLY;
                end else if (!armed_q) begin
                    cnt_load = 1'b1;
                    cnt_val  = wait_len - DIV_W'(2);
                    armed_d  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_APPLY:  state_d = ST_ENABLE;
            ST_ENABLE: state_d = ST_RUN;
            default:   state_d = ST_HOLD_RST;
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_HOLD_RST;
            armed_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_ratio_q <= DEF_R;
            o_div_ratio  <= DEF_R;
            o_div_clk_en <= 1'b0;
            o_div_rst_n  <= 1'b0;
            o_req_ready  <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_busy       <= 1'b1;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            o_req_ready  <= (state_d == ST_RUN);
            o_busy       <= (state_d != ST_RUN);
            o_div_rst_n  <= (state_d != ST_HOLD_RST);
            o_div_clk_en <= (state_d == ST_RUN) && i_en;
            o_err        <= accept && !legal;
            o_done       <= (accept && legal && same) || ((state_q == ST_ENABLE) && pend_q);
            if (accept && legal && !same) begin
                pend_q       <= 1'b1;
                pend_ratio_q <= i_req_ratio;
            end else if (state_q == ST_ENABLE) begin
                pend_q <= 1'b0;
            end
            // New ratio lands on the edge entering APPLY, while the divider still sees reset.
            if ((state_d == ST_APPLY) && pend_q) o_div_ratio <= pend_ratio_q;
        end
    end

endmodule

// File: tb/tb_clk_div_reconfig_ctrl.sv
// Directed bench for clk_div_reconfig_ctrl with a pulse scoreboard on o_done/o_err.
module tb_clk_div_reconfig_ctrl;

    localparam int K_NONE = 0;
    localparam int K_CHG  = 1;
    localparam int K_SAME = 2;
    localparam int K_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_en;
    logic        req_valid;
    logic [31:0] req_ratio;
    logic        o_req_ready, o_done, o_err, o_busy, o_div_clk_en, o_div_rst_n;
    logic [31:0] o_div_ratio;
    logic [2:0]  o_dbg_state;

    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [49:0] exp_q[$];
    logic [49:0] mon_got, mon_exp;

    clk_div_reconfig_ctrl dut (
        .i_ref_clk    (clk),
        .i_rst_n      (rst_n),
        .i_en         (i_en),
        .i_req_valid  (req_valid),
        .i_req_ratio  (req_ratio),
        .o_req_ready  (o_req_ready),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_busy       (o_busy),
        .o_div_ratio  (o_div_ratio),
        .o_div_clk_en (o_div_clk_en),
        .o_div_rst_n  (o_div_rst_n),
        .o_dbg_state  (o_dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // scoreboard monitor: every o_done/o_err pulse must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && (o_done || o_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse done=%0b err=%0b ratio=%0d cyc=%0d",
                         o_done, o_err, o_div_ratio, cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_got = {16'(cyc), o_err, o_done, o_div_ratio};
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL pulse got cyc=%0d err=%0b done=%0b ratio=%0d exp cyc=%0d err=%0b done=%0b ratio=%0d",
                             mon_got[49:34], mon_got[33], mon_got[32], mon_got[31:0],
                             mon_exp[49:34], mon_exp[33], mon_exp[32], mon_exp[31:0]);
                end
            end
        end
    end

    // driver: present a request, wait for ready, record accept edge and expected pulse
    task automatic send(input logic [31:0] r, input logic [31:0] old_r, input int kind, output int e0);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_ratio = r;
        while (!o_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout got=ready0 exp=ready1 cyc=%0d", cyc);
            req_valid = 1'b0;
            e0 = -1;
            return;
        end
        e0 = cyc + 1;
        case (kind)
            K_CHG:  exp_q.push_back({16'(e0 + int'(old_r) + 4), 1'b0, 1'b1, r});
            K_SAME: exp_q.push_back({16'(e0), 1'b0, 1'b1, r});
            K_ERR:  exp_q.push_back({16'(e0), 1'b1, 1'b0, old_r});
            default: ;
        endcase
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_req_ready && !o_busy) && n < 100);
        chk("idle_timeout", {31'd0, o_req_ready}, 32'd1);
    endtask

    task automatic chk_reset();
        chk("rst_state", {29'd0, o_dbg_state}, 32'd1);
        chk("rst_ratio", o_div_ratio, 32'd2);
        chk("rst_clk_en", {31'd0, o_div_clk_en}, 32'd0);
        chk("rst_div_rst_n", {31'd0, o_div_rst_n}, 32'd0);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd1);
    endtask

    // called on the negedge where reset was released; i_en is high
    task automatic pwr_check();
        int exp_rst[4] = '{0, 1, 1, 1};
        int exp_en[4]  = '{0, 0, 0, 1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("pwr_div_rst_n", {31'd0, o_div_rst_n}, 32'(exp_rst[k]));
            chk("pwr_clk_en", {31'd0, o_div_clk_en}, 32'(exp_en[k]));
        end
        chk("pwr_ratio", o_div_ratio, 32'd2);
    endtask

    initial begin
        int e0, e0a, e0b;
        int exp_rst[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
        int exp_en[8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
        int exp_rat[8] = '{4, 4, 4, 4, 4, 7, 7, 7};
        int bad[3]     = '{0, 1, 1025};

        rst_n = 1'b0;
        i_en = 1'b1;
        req_valid = 1'b0;
        req_ratio = '0;
        repeat (3) @(negedge clk);
        chk_reset();
        rst_n = 1'b1;
        pwr_check();

        send(32'd4, 32'd2, K_CHG, e0);
        wait_idle();

        // 4 -> 7 with per-cycle view of the sequence
        send(32'd7, 32'd4, K_CHG, e0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("chg_div_rst_n", {31'd0, o_div_rst_n}, 32'(exp_rst[k]));
            chk("chg_clk_en", {31'd0, o_div_clk_en}, 32'(exp_en[k]));
            chk("chg_ratio", o_div_ratio, 32'(exp_rat[k]));
        end
        wait_idle();

        foreach (bad[i]) begin
            send(32'(bad[i]), 32'd7, K_ERR, e0);
            chk("err_ratio_kept", o_div_ratio, 32'd7);
            chk("err_clk_en_kept", {31'd0, o_div_clk_en}, 32'd1);
        end

        // enable gating and a change accepted with i_en low
        @(negedge clk);
        i_en = 1'b0;
        @(negedge clk);
        chk("en_off", {31'd0, o_div_clk_en}, 32'd0);
        send(32'd6, 32'd7, K_CHG, e0);
        wait_idle();
        chk("en_low_ratio", o_div_ratio, 32'd6);
        chk("en_low_clk_en", {31'd0, o_div_clk_en}, 32'd0);
        i_en = 1'b1;
        @(negedge clk);
        chk("en_on", {31'd0, o_div_clk_en}, 32'd1);

        send(32'd6, 32'd6, K_SAME, e0);
        for (int k = 0; k < 3; k++) begin
            chk("same_clk_en", {31'd0, o_div_clk_en}, 32'd1);
            chk("same_busy", {31'd0, o_busy}, 32'd0);
            @(negedge clk);
        end

        // back-to-back: second request stalls until the first RUN cycle
        send(32'd3, 32'd6, K_CHG, e0a);
        send(32'd5, 32'd3, K_CHG, e0b);
        chk("b2b_accept_cycle", 32'(e0b), 32'(e0a + 11));
        wait_idle();
        chk("b2b_ratio", o_div_ratio, 32'd5);

        // reset during HOLD_RST of a 4 -> 9 change
        send(32'd4, 32'd5, K_CHG, e0);
        wait_idle();
        send(32'd9, 32'd4, K_NONE, e0);
        repeat (4) @(negedge clk);
        chk("abort_in_hold", {29'd0, o_dbg_state}, 32'd1);
        chk("abort_hold_rst_n", {31'd0, o_div_rst_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk_reset();
        @(negedge clk);
        rst_n = 1'b1;
        pwr_check();

        repeat (10) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
